insn_mem_loader: RTL and testbench

INSN_MEM_LOADER -- requirements
Module: insn_mem_loader

---
 rtl/insn_mem_loader.sv | 111 +++++++++++
 tb/tb_insn_mem_loader.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/insn_mem_loader.sv
// Streams bytes into 32-bit little-endian words and writes them to an instruction memory.
// The CPU is held (busy) while a load runs; done pulses once at the end of every load.
module insn_mem_loader #(
    parameter int MEM_BYTES = 256,
    parameter int MAX_WORDS = MEM_BYTES / 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [6:0]  load_len,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic        in_ready,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

    localparam logic [6:0] MAX_LEN = 7'(MAX_WORDS);

    state_t      state_r;
    logic [6:0]  len_r;
    logic [6:0]  word_idx_r;
    logic [1:0]  byte_cnt_r;
    logic [23:0] word_r;

    // Load sequencer; every output is a register updated with the state transition.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            len_r      <= 7'd0;
            word_idx_r <= 7'd0;
            byte_cnt_r <= 2'd0;
            word_r     <= 24'd0;
            in_ready   <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 8'd0;
            mem_wdata  <= 32'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        len_r      <= load_len;
                        word_idx_r <= 7'd0;
                        byte_cnt_r <= 2'd0;
                        err        <= (load_len > MAX_LEN);
                        if ((load_len == 7'd0) || (load_len > MAX_LEN)) begin
                            state_r <= DONE;
                            done    <= 1'b1;
                        end else begin
                            state_r  <= RECV;
                            in_ready <= 1'b1;
                            busy     <= 1'b1;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RECV: begin
                    if (in_valid) begin
                        byte_cnt_r <= byte_cnt_r + 2'd1;
                        if (byte_cnt_r == 2'd3) begin
                            // Byte 3 goes straight into the top lane of the write word.
                            mem_wdata <= {in_byte, word_r};
                            mem_addr  <= {word_idx_r[5:0], 2'b00};
                            mem_we    <= 1'b1;
                            in_ready  <= 1'b0;
                            state_r   <= WRITE;
                        end else begin
                            word_r[{byte_cnt_r, 3'b000} +: 8] <= in_byte;
                        end
                    end else begin
                        state_r <= RECV;
                    end
                end
                WRITE: begin
                    mem_we     <= 1'b0;
                    word_idx_r <= word_idx_r + 7'd1;
                    if ((word_idx_r + 7'd1) == len_r) begin
                        state_r <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        state_r  <= RECV;
                        in_ready <= 1'b1;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r  <= IDLE;
                    in_ready <= 1'b0;
                    mem_we   <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_insn_mem_loader.sv
// Randomised bench for insn_mem_loader: a reference model fills expectation queues,
// a negedge monitor pops and compares every write and done pulse.
module tb_insn_mem_loader;

    typedef logic [7:0] byte_q_t[$];
    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [6:0]  load_len = 7'd0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_byte = 8'd0;
    logic        in_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;

    wr_t  exp_w[$];
    bit   exp_err_q[$];
    bit   exp_hasw_q[$];
    wr_t  mon_w;
    bit   mon_e;
    bit   mon_h;
    logic prev_we = 1'b0;
    logic [7:0] last_addr = 8'd0;

    insn_mem_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .load_len(load_len),
        .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic fail_msg(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    // Monitor: every write and done pulse is matched against the model's queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_ready) check("ready_implies_busy", 32'(busy), 32'd1);
            if (mem_we) begin
                check("we_single_cycle", 32'(prev_we), 32'd0);
                if (exp_w.size() == 0) begin
                    fail_msg("unexpected_write");
                end else begin
                    mon_w = exp_w.pop_front();
                    check("write_addr", 32'(mem_addr), 32'(mon_w.addr));
                    check("write_data", mem_wdata, mon_w.data);
                end
                last_addr <= mem_addr;
            end
            if (done) begin
                done_cnt++;
                if (exp_err_q.size() == 0) begin
                    fail_msg("unexpected_done");
                end else begin
                    mon_e = exp_err_q.pop_front();
                    mon_h = exp_hasw_q.pop_front();
                    check("done_err", 32'(err), 32'(mon_e));
                    check("done_busy_low", 32'(busy), 32'd0);
                    check("done_after_write", 32'(prev_we), 32'(mon_h));
                end
            end
            prev_we <= mem_we;
        end else begin
            prev_we <= 1'b0;
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_busy_done_err", {29'd0, busy, done, err}, 32'd0);
        rst_n = 1'b1;
    endtask

    task automatic issue_start(input logic [6:0] len);
        start = 1'b1;
        load_len = len;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Offers the bytes with in_valid asserted pct% of cycles; optionally pokes start mid-load.
    task automatic feed(input byte_q_t bytes, input int pct, input bit poke);
        int i = 0;
        int guard = 0;
        bit v;
        logic rdy;
        while (i < bytes.size() && guard < 5000) begin
            v = ($urandom_range(99) < pct);
            in_valid = v;
            in_byte = v ? bytes[i] : 8'($urandom);
            start = poke && (i >= 10) && (i < 14);
            load_len = 7'd5;
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (v && rdy) i++;
            guard++;
        end
        in_valid = 1'b0;
        start = 1'b0;
        if (guard >= 5000) fail_msg("feed_timeout");
    endtask

    task automatic run_load(input logic [6:0] len, input byte_q_t bytes, input int pct, input bit poke);
        int target;
        bit bad;
        wr_t w;
        bad = (len == 7'd0) || (len > 7'd64);
        if (!bad) begin
            for (int k = 0; k < int'(len); k++) begin
                w.addr = 8'(k * 4);
                w.data = {bytes[4*k+3], bytes[4*k+2], bytes[4*k+1], bytes[4*k]};
                exp_w.push_back(w);
            end
        end
        exp_err_q.push_back(len > 7'd64);
        exp_hasw_q.push_back(!bad);
        target = done_cnt + 1;
        issue_start(len);
        if (!bad) feed(bytes, pct, poke);
        for (int c = 0; c < 200 && done_cnt < target; c++) @(posedge clk);
        #1;
        if (done_cnt != target) fail_msg("done_timeout");
        check("post_busy", 32'(busy), 32'd0);
        check("pending_writes", 32'(exp_w.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("err_sticky", 32'(err), 32'(len > 7'd64));
    endtask

    initial begin
        byte_q_t b;
        int n;
        do_reset();

        b = '{8'h13, 8'h00, 8'h00, 8'h00};
        run_load(7'd1, b, 100, 1'b0);

        b = '{8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01, 8'h20, 8'h00};
        run_load(7'd2, b, 100, 1'b0);
        run_load(7'd2, b, 40, 1'b0);

        b = {};
        run_load(7'd0, b, 100, 1'b0);
        run_load(7'd65, b, 100, 1'b0);
        b = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        run_load(7'd1, b, 100, 1'b0);
        b = {};
        run_load(7'd127, b, 100, 1'b0);

        b = {};
        for (int k = 0; k < 256; k++) b.push_back(8'($urandom));
        run_load(7'd64, b, 70, 1'b1);
        check("full_load_last_addr", 32'(last_addr), 32'd252);

        // Abort after two bytes of word 0; nothing may be written or signalled.
        issue_start(7'd1);
        b = '{8'hEE, 8'hFF};
        feed(b, 100, 1'b0);
        do_reset();
        b = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_load(7'd1, b, 100, 1'b0);

        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(8, 1);
            b = {};
            for (int k = 0; k < 4 * n; k++) b.push_back(8'($urandom));
            run_load(7'(n), b, $urandom_range(90, 30), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
